// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back / write-allocate line cache with its own
// controller, tree pseudo-LRU replacement and a whole-cache flush mode.
module cache_nway_wb #(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int WAYS     = 4,
  localparam int LINE    = 8 * (2 ** S_OFFSET),
  localparam int S_TAG   = 32 - S_OFFSET - S_INDEX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [LINE-1:0]   mem_wdata256,
  input  logic [LINE/8-1:0] mem_byte_enable256,
  output logic [LINE-1:0]   mem_rdata256,
  output logic              mem_resp,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE-1:0]   pmem_wdata,
  input  logic [LINE-1:0]   pmem_rdata,
  input  logic              pmem_resp,
  input  logic              flush,
  output logic              flush_busy
);
  localparam int SETS = 2 ** S_INDEX;
  localparam int LW   = $clog2(WAYS);
  localparam int NB   = LINE / 8;

  typedef enum logic [1:0] {CHECK, WB, FILL, FLUSH} state_t;
  state_t state, next_state;

  logic [LINE-1:0]  data_arr  [WAYS][SETS];
  logic [S_TAG-1:0] tag_arr   [WAYS][SETS];
  logic [SETS-1:0]  valid_arr [WAYS];
  logic [SETS-1:0]  dirty_arr [WAYS];
  logic [WAYS-2:0]  plru_arr  [SETS];

  logic                  flush_pending;
  logic [S_INDEX+LW-1:0] flush_cnt;
  logic [LW-1:0]         victim_q;

  logic [S_INDEX-1:0] idx;
  logic [S_TAG-1:0]   tag;
  logic               req;
  logic               unused_offset;

  assign idx           = mem_address[S_OFFSET +: S_INDEX];
  assign tag           = mem_address[31 -: S_TAG];
  assign req           = mem_read | mem_write;
  assign unused_offset = ^mem_address[S_OFFSET-1:0];

  // Flush scan position: low bits pick the way, high bits the set.
  logic [LW-1:0]      fl_way;
  logic [S_INDEX-1:0] fl_set;
  logic               fl_dirty;
  logic               flush_last;
  logic               flush_adv;

  assign fl_way     = flush_cnt[LW-1:0];
  assign fl_set     = flush_cnt[LW +: S_INDEX];
  assign fl_dirty   = valid_arr[fl_way][fl_set] & dirty_arr[fl_way][fl_set];
  assign flush_last = &flush_cnt;
  assign flush_busy = flush_pending;

  // Each access points every tree node on the way's path at the other half.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] cur,
                                                 input logic [LW-1:0]   w);
    logic [WAYS-2:0] r;
    logic [LW:0]     n;
    logic            b;
    r = cur;
    n = (LW+1)'(1);
    for (int l = 0; l < LW; l++) begin
      b = w[LW-1-l];
      r[LW'(n - 1'b1)] = ~b;
      n = {n[LW-1:0], b};
    end
    return r;
  endfunction

  // Tag compare across all ways of the addressed set.
  logic          hit_any;
  logic [LW-1:0] hit_way;
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_arr[w][idx] && tag_arr[w][idx] == tag) begin
        hit_any = 1'b1;
        hit_way = LW'(w);
      end
    end
  end

  // Victim choice: lowest invalid way wins, otherwise walk the PLRU tree.
  logic [LW-1:0] miss_victim;
  logic [LW:0]   walk;
  always_comb begin
    walk = (LW+1)'(1);
    for (int l = 0; l < LW; l++) begin
      walk = {walk[LW-1:0], plru_arr[idx][LW'(walk - 1'b1)]};
    end
    miss_victim = walk[LW-1:0];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_arr[w][idx]) miss_victim = LW'(w);
    end
  end

  // Controller next-state and memory-side handshake outputs.
  logic [LW-1:0]      wb_way;
  logic [S_INDEX-1:0] wb_set;
  always_comb begin
    next_state   = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    flush_adv    = 1'b0;
    wb_way       = victim_q;
    wb_set       = idx;
    case (state)
      CHECK: begin
        if (flush_pending) begin
          next_state = FLUSH;
        end else if (req) begin
          if (hit_any) mem_resp = 1'b1;
          else if (valid_arr[miss_victim][idx] && dirty_arr[miss_victim][idx]) next_state = WB;
          else next_state = FILL;
        end
      end
      WB: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[victim_q][idx], idx, {S_OFFSET{1'b0}}};
        if (pmem_resp) next_state = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {tag, idx, {S_OFFSET{1'b0}}};
        if (pmem_resp) next_state = CHECK;
      end
      FLUSH: begin
        wb_way = fl_way;
        wb_set = fl_set;
        if (fl_dirty) begin
          pmem_write   = 1'b1;
          pmem_address = {tag_arr[fl_way][fl_set], fl_set, {S_OFFSET{1'b0}}};
          flush_adv    = pmem_resp;
        end else begin
          flush_adv = 1'b1;
        end
        if (flush_adv && flush_last) next_state = CHECK;
      end
      default: next_state = CHECK;
    endcase
  end

  assign pmem_wdata   = data_arr[wb_way][wb_set];
  assign mem_rdata256 = data_arr[hit_way][idx];

  // State register; reset aborts any memory transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CHECK;
    else      state <= next_state;
  end

  // Line metadata, replacement state, flush bookkeeping and latched victim.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_arr[w] <= '0;
        dirty_arr[w] <= '0;
        for (int s = 0; s < SETS; s++) tag_arr[w][s] <= '0;
      end
      for (int s = 0; s < SETS; s++) plru_arr[s] <= '0;
      flush_pending <= 1'b0;
      flush_cnt     <= '0;
      victim_q      <= '0;
    end else begin
      if (flush && !flush_pending) flush_pending <= 1'b1;
      case (state)
        CHECK: begin
          if (mem_resp) begin
            plru_arr[idx] <= plru_touch(plru_arr[idx], hit_way);
            if (mem_write) dirty_arr[hit_way][idx] <= 1'b1;
          end else if (!flush_pending && req) begin
            victim_q <= miss_victim;
          end
        end
        WB: begin
          if (pmem_resp) dirty_arr[victim_q][idx] <= 1'b0;
        end
        FILL: begin
          if (pmem_resp) begin
            tag_arr[victim_q][idx]   <= tag;
            valid_arr[victim_q][idx] <= 1'b1;
            dirty_arr[victim_q][idx] <= 1'b0;
          end
        end
        FLUSH: begin
          if (flush_adv) begin
            if (fl_dirty) dirty_arr[fl_way][fl_set] <= 1'b0;
            flush_cnt <= flush_cnt + 1'b1;
            if (flush_last) flush_pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage: byte-masked write on a write hit, whole line on fill.
  always_ff @(posedge clk) begin
    if (state == CHECK && mem_resp && mem_write) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_byte_enable256[b]) data_arr[hit_way][idx][8*b +: 8] <= mem_wdata256[8*b +: 8];
      end
    end
    if (state == FILL && pmem_resp) data_arr[victim_q][idx] <= pmem_rdata;
  end

endmodule

// File: tb/tb_cache_nway_wb.sv
// Directed self-checking bench for cache_nway_wb (WAYS=4, 8 sets, 32-byte lines).
module tb_cache_nway_wb;
  logic         clk;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_wdata256;
  logic [31:0]  mem_byte_enable256;
  logic [255:0] mem_rdata256;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         flush;
  logic         flush_busy;

  int errors = 0;
  int checks = 0;

  cache_nway_wb dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata256(mem_wdata256), .mem_byte_enable256(mem_byte_enable256),
    .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .flush(flush), .flush_busy(flush_busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream of every bounded wait goes wrong.
  initial begin
    #400000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  // Line with eight distinct words so byte-lane mistakes are visible.
  function automatic logic [255:0] mkLine(input logic [31:0] seed);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = seed + 32'(i);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic rd, input logic wr,
                               input logic [31:0] be, input logic [255:0] wdata);
    mem_address        = addr;
    mem_read           = rd;
    mem_write          = wr;
    mem_byte_enable256 = be;
    mem_wdata256       = wdata;
  endtask

  task automatic applyIdle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Wait for a memory request, check it, then answer it for one cycle.
  task automatic waitMem(input string tag, input logic isWr, input logic [31:0] addr,
                         input logic [255:0] wexp, input logic [255:0] rdat);
    int n = 0;
    while (!(pmem_read | pmem_write) && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    checkOutput({tag, " seen"}, 256'(pmem_read | pmem_write), 256'(1));
    checkOutput({tag, " pmem_write"}, 256'(pmem_write), 256'(isWr));
    checkOutput({tag, " pmem_read"}, 256'(pmem_read), 256'(!isWr));
    checkOutput({tag, " addr"}, 256'(pmem_address), 256'(addr));
    if (isWr) checkOutput({tag, " wdata"}, pmem_wdata, wexp);
    pmem_rdata = rdat;
    pmem_resp  = 1'b1;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    #1;
  endtask

  // Hit: response in the same cycle, no memory traffic.
  task automatic hitAccess(input string tag, input logic [31:0] addr, input logic wr,
                           input logic [31:0] be, input logic [255:0] wdata,
                           input logic chkData, input logic [255:0] expData);
    applyStimulus(addr, !wr, wr, be, wdata);
    #1;
    checkOutput({tag, " mem_resp"}, 256'(mem_resp), 256'(1));
    checkOutput({tag, " no_pmem"}, 256'(pmem_read | pmem_write), 256'(0));
    if (chkData) checkOutput({tag, " rdata"}, mem_rdata256, expData);
    @(posedge clk); #1;
    applyIdle();
  endtask

  // Miss: optional write-back, then fill, then response one cycle later.
  task automatic missAccess(input string tag, input logic [31:0] addr, input logic wr,
                            input logic [31:0] be, input logic [255:0] wdata,
                            input logic hasWb, input logic [31:0] wbAddr,
                            input logic [255:0] wbData, input logic [255:0] fillData);
    applyStimulus(addr, !wr, wr, be, wdata);
    #1;
    checkOutput({tag, " miss_no_resp"}, 256'(mem_resp), 256'(0));
    if (hasWb) waitMem({tag, " wb"}, 1'b1, wbAddr, wbData, '0);
    waitMem({tag, " fill"}, 1'b0, addr & 32'hFFFF_FFE0, '0, fillData);
    checkOutput({tag, " resp_after_fill"}, 256'(mem_resp), 256'(1));
    checkOutput({tag, " rdata"}, mem_rdata256, fillData);
    @(posedge clk); #1;
    applyIdle();
  endtask

  // Pulse flush and let the scan run, answering each write-back at once.
  task automatic flushRun(input string tag, input int expN,
                          input logic [31:0] a0, input logic [255:0] d0,
                          input logic [31:0] a1, input logic [255:0] d1);
    int cyc = 0;
    int nw  = 0;
    int nr  = 0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    checkOutput({tag, " busy_high"}, 256'(flush_busy), 256'(1));
    while (flush_busy && cyc < 200) begin
      if (pmem_read) nr++;
      if (pmem_write) begin
        if (nw == 0) begin
          checkOutput({tag, " wb0 addr"}, 256'(pmem_address), 256'(a0));
          checkOutput({tag, " wb0 data"}, pmem_wdata, d0);
        end else if (nw == 1) begin
          checkOutput({tag, " wb1 addr"}, 256'(pmem_address), 256'(a1));
          checkOutput({tag, " wb1 data"}, pmem_wdata, d1);
        end
        nw++;
        pmem_resp = 1'b1;
      end
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      #1;
      cyc++;
    end
    checkOutput({tag, " writes"}, 256'(nw), 256'(expN));
    checkOutput({tag, " reads"}, 256'(nr), 256'(0));
    checkOutput({tag, " busy_cycles"}, 256'(cyc), 256'(33));
    checkOutput({tag, " busy_low"}, 256'(flush_busy), 256'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [255:0] lineA, l0, l1, l2, l3, l4, l5, l6, l7;
    logic [255:0] ff, dead, bad, cafe, mergedA, w0, w6;
    int n;
    lineA = mkLine(32'hA0A0_0000);
    l0 = mkLine(32'h1000_0000); l1 = mkLine(32'h1100_0000);
    l2 = mkLine(32'h1200_0000); l3 = mkLine(32'h1300_0000);
    l4 = mkLine(32'h1400_0000); l5 = mkLine(32'h1500_0000);
    l6 = mkLine(32'h1600_0000); l7 = mkLine(32'h1700_0000);
    ff   = {8{32'hFFFF_FFFF}};
    dead = {8{32'hDEAD_BEEF}};
    bad  = {8{32'h0BAD_F00D}};
    cafe = {8{32'hCAFE_F00D}};
    mergedA = {lineA[255:32], 32'hFFFF_FFFF};
    w0 = {l0[255:64], 64'hDEAD_BEEF_DEAD_BEEF};
    w6 = {32'hCAFE_F00D, l6[223:0]};

    rst = 1'b0; flush = 1'b0; pmem_resp = 1'b0; pmem_rdata = '0;
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, '0);

    // Reset state
    #2;
    checkOutput("reset mem_resp", 256'(mem_resp), 256'(0));
    checkOutput("reset pmem_read", 256'(pmem_read), 256'(0));
    checkOutput("reset pmem_write", 256'(pmem_write), 256'(0));
    checkOutput("reset flush_busy", 256'(flush_busy), 256'(0));
    checkOutput("reset pmem_address", 256'(pmem_address), 256'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: read miss and fill, then a same-cycle hit
    $display("[TB] step 1: read miss/fill/hit");
    missAccess("t1 miss 0x40", 32'h40, 1'b0, '0, '0, 1'b0, '0, '0, lineA);
    hitAccess("t1 hit 0x40", 32'h40, 1'b0, '0, '0, 1'b1, lineA);

    // 2: byte-masked write hit; flush proves the line went dirty
    $display("[TB] step 2: write hit");
    hitAccess("t2 write 0x40", 32'h40, 1'b1, 32'h0000_000F, ff, 1'b0, '0);
    hitAccess("t2 reread 0x40", 32'h44, 1'b0, '0, '0, 1'b1, mergedA);
    flushRun("t2 flush", 1, 32'h40, mergedA, 32'h0, '0);

    // 3: fill all four ways of set 0, touch in order, PLRU evicts way 0
    $display("[TB] step 3: PLRU");
    missAccess("t3 fill 0x000", 32'h000, 1'b0, '0, '0, 1'b0, '0, '0, l0);
    missAccess("t3 fill 0x100", 32'h100, 1'b0, '0, '0, 1'b0, '0, '0, l1);
    missAccess("t3 fill 0x200", 32'h200, 1'b0, '0, '0, 1'b0, '0, '0, l2);
    missAccess("t3 fill 0x300", 32'h300, 1'b0, '0, '0, 1'b0, '0, '0, l3);
    hitAccess("t3 hit 0x000", 32'h000, 1'b0, '0, '0, 1'b1, l0);
    hitAccess("t3 hit 0x100", 32'h100, 1'b0, '0, '0, 1'b1, l1);
    hitAccess("t3 hit 0x200", 32'h200, 1'b0, '0, '0, 1'b1, l2);
    hitAccess("t3 hit 0x300", 32'h300, 1'b0, '0, '0, 1'b1, l3);
    missAccess("t3 evict for 0x400", 32'h400, 1'b0, '0, '0, 1'b0, '0, '0, l4);

    // 4: 0x000 now misses (write-allocate into way 2), then evict it dirty
    $display("[TB] step 4: dirty eviction");
    missAccess("t4 write miss 0x000", 32'h000, 1'b1, 32'h0000_00FF, dead, 1'b0, '0, '0, l0);
    hitAccess("t4 hit 0x300", 32'h300, 1'b0, '0, '0, 1'b1, l3);
    hitAccess("t4 hit 0x400", 32'h400, 1'b0, '0, '0, 1'b1, l4);
    missAccess("t4 read 0x500", 32'h500, 1'b0, '0, '0, 1'b1, 32'h000, w0, l5);

    // 5: two dirty lines, flush writes exactly those, later reads hit
    $display("[TB] step 5: flush");
    missAccess("t5 write 0x000", 32'h000, 1'b1, 32'hFFFF_FFFF, bad, 1'b0, '0, '0, l0);
    missAccess("t5 write 0x1A0", 32'h1A0, 1'b1, 32'hF000_0000, cafe, 1'b0, '0, '0, l6);
    flushRun("t5 flush", 2, 32'h000, bad, 32'h1A0, w6);
    hitAccess("t5 hit 0x000", 32'h000, 1'b0, '0, '0, 1'b1, bad);
    hitAccess("t5 hit 0x1A0", 32'h1A0, 1'b0, '0, '0, 1'b1, w6);

    // 6: reset in the middle of a fill
    $display("[TB] step 6: reset during fill");
    applyStimulus(32'h600, 1'b1, 1'b0, '0, '0);
    #1;
    n = 0;
    while (!pmem_read && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    checkOutput("t6 fill started", 256'(pmem_read), 256'(1));
    checkOutput("t6 fill addr", 256'(pmem_address), 256'(32'h600));
    rst = 1'b0;
    #1;
    checkOutput("t6 reset pmem_read", 256'(pmem_read), 256'(0));
    checkOutput("t6 reset pmem_write", 256'(pmem_write), 256'(0));
    checkOutput("t6 reset pmem_address", 256'(pmem_address), 256'(0));
    checkOutput("t6 reset mem_resp", 256'(mem_resp), 256'(0));
    applyIdle();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    missAccess("t6 re-miss 0x600", 32'h600, 1'b0, '0, '0, 1'b0, '0, '0, l7);
    missAccess("t6 0x40 invalid", 32'h40, 1'b0, '0, '0, 1'b0, '0, '0, l2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
